// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: arbiter state encoding
// and the minimum legal memory latency.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    localparam int MEM_LAT_MIN = 1;

endpackage

// File: rtl/mem_port_arbiter_fetch_hold_buf.sv
// Holds a completed instruction fetch until the pipeline consumes it, and
// discards fetches that were in flight when a redirect (flush) occurred.
module fetch_hold_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy_fetch_i,
    input  logic              access_done_i,
    input  logic              fetch_done_i,
    input  logic              flush_i,
    input  logic              consume_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              hold_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o
);

    logic              hold_q;
    logic              drop_q;
    logic [DATA_W-1:0] data_q;
    logic              capture;

    // A completing fetch is usable only if no redirect touched it.
    assign capture = fetch_done_i & ~drop_q & ~flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= 1'b0;
            drop_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (flush_i || consume_i) begin
                hold_q <= 1'b0;
            end else if (capture) begin
                hold_q <= 1'b1;
                data_q <= rdata_i;
            end

            // The discarded access still runs; its marker dies with it.
            if (access_done_i) begin
                drop_q <= 1'b0;
            end else if (flush_i && busy_fetch_i) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign hold_o  = hold_q;
    assign ready_o = hold_q | capture;
    assign data_o  = fetch_done_i ? rdata_i : data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for IF and MEM stages: data accesses first,
// fixed-latency sequencing, fetch buffering and pipeline freeze controls.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              flush,
    input  logic              hz_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              PCwrite,
    output logic              if_id_write,
    output logic              mem_stall
);

    localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < MEM_LAT_MIN) begin : g_lat_check
            $error("mem_port_arbiter: LATENCY must be at least MEM_LAT_MIN");
        end
    endgenerate

    arb_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic busy;
    logic access_done;
    logic data_done;
    logic fetch_done;
    logic hold;
    logic pc_write;

    assign busy        = (state_q != ARB_IDLE);
    assign access_done = busy && (cnt_q == '0);
    assign data_done   = (state_q == ARB_BUSY_D) && access_done;
    assign fetch_done  = (state_q == ARB_BUSY_I) && access_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (d_req) begin
                        state_q <= ARB_BUSY_D;
                        cnt_q   <= CNT_INIT;
                        addr_q  <= d_addr;
                        we_q    <= d_we;
                        wdata_q <= d_wdata;
                    end else if (i_req && !hold) begin
                        state_q <= ARB_BUSY_I;
                        cnt_q   <= CNT_INIT;
                        addr_q  <= i_addr;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                    end
                end
                ARB_BUSY_I, ARB_BUSY_D: begin
                    if (cnt_q == '0) begin
                        state_q <= ARB_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase

            if (data_done) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    // Memory port is a pure function of registered state, so reset drops it at once.
    assign mem_en    = busy;
    assign mem_we    = (state_q == ARB_BUSY_D) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign d_ready = data_done;
    assign d_rdata = data_done ? mem_rdata : d_rdata_q;

    fetch_hold_buf #(
        .DATA_W(DATA_W)
    ) u_fetch_hold_buf (
        .clk          (clk),
        .rst          (rst),
        .busy_fetch_i (state_q == ARB_BUSY_I),
        .access_done_i(access_done),
        .fetch_done_i (fetch_done),
        .flush_i      (flush),
        .consume_i    (pc_write),
        .rdata_i      (mem_rdata),
        .hold_o       (hold),
        .ready_o      (i_ready),
        .data_o       (i_rdata)
    );

    assign mem_stall   = d_req & ~d_ready;
    assign pc_write    = i_ready & ~mem_stall & ~hz_stall & ~flush;
    assign PCwrite     = pc_write;
    assign if_id_write = pc_write;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (LATENCY=2): a per-cycle vector table
// plus hand-written reset sequences.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          flush;
    logic          hz_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          PCwrite;
    logic          if_id_write;
    logic          mem_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .LATENCY(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .flush      (flush),
        .hz_stall   (hz_stall),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .PCwrite    (PCwrite),
        .if_id_write(if_id_write),
        .mem_stall  (mem_stall)
    );

    typedef struct {
        logic          ir;
        logic [31:0]   ia;
        logic          dr;
        logic          dw;
        logic [31:0]   da;
        logic [31:0]   dwd;
        logic          fl;
        logic          hz;
        logic [31:0]   rd;
        logic          e_en;
        logic          e_we;
        logic [31:0]   e_addr;
        logic          e_iry;
        logic [31:0]   e_ird;
        logic          e_dry;
        logic [31:0]   e_drd;
        logic          e_pcw;
        logic          e_ms;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input vec_t v);
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_idle();
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
        d_wdata = '0; flush = 1'b0; hz_stall = 1'b0; mem_rdata = '0;
    endtask

    task automatic apply(input vec_t v, input int cyc);
        @(negedge clk);
        i_req = v.ir; i_addr = v.ia; d_req = v.dr; d_we = v.dw; d_addr = v.da;
        d_wdata = v.dwd; flush = v.fl; hz_stall = v.hz; mem_rdata = v.rd;
        #1;
        chk("mem_en", cyc, 32'(mem_en), 32'(v.e_en));
        chk("mem_we", cyc, 32'(mem_we), 32'(v.e_we));
        if (v.e_en) chk("mem_addr", cyc, mem_addr, v.e_addr);
        chk("i_ready", cyc, 32'(i_ready), 32'(v.e_iry));
        if (v.e_iry) chk("i_rdata", cyc, i_rdata, v.e_ird);
        chk("d_ready", cyc, 32'(d_ready), 32'(v.e_dry));
        chk("d_rdata", cyc, d_rdata, v.e_drd);
        chk("PCwrite", cyc, 32'(PCwrite), 32'(v.e_pcw));
        chk("if_id_write", cyc, 32'(if_id_write), 32'(v.e_pcw));
        chk("mem_stall", cyc, 32'(mem_stall), 32'(v.e_ms));
        $display("cycle %0d: en=%b we=%b addr=%h i_ready=%b i_rdata=%h d_ready=%b d_rdata=%h pcw=%b stall=%b",
                 cyc, mem_en, mem_we, mem_addr, i_ready, i_rdata, d_ready, d_rdata, PCwrite, mem_stall);
    endtask

    initial begin
        // Fields: ir ia dr dw da dwd fl hz rd | en we addr iry ird dry drd pcw ms
        // Fetch of 0x0 after reset
        add(vec_t'{1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 0});
        add(vec_t'{1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,        1, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 0});
        add(vec_t'{1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h8C010004, 1, 0, 32'h0,   1, 32'h8C010004, 0, 32'h0,        1, 0});
        // Simultaneous requests: data first, then fetch of 0x4
        add(vec_t'{1, 32'h4, 1, 0, 32'h100, 32'h0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 1});
        add(vec_t'{1, 32'h4, 1, 0, 32'h100, 32'h0, 0, 0, 32'h0,        1, 0, 32'h100, 0, 32'h0,        0, 32'h0,        0, 1});
        add(vec_t'{1, 32'h4, 1, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1, 0, 32'h100, 0, 32'h0,        1, 32'hDEADBEEF, 0, 0});
        add(vec_t'{1, 32'h4, 0, 0, 32'h0,   32'h0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        0, 32'hDEADBEEF, 0, 0});
        add(vec_t'{1, 32'h4, 0, 0, 32'h0,   32'h0, 0, 0, 32'h0,        1, 0, 32'h4,   0, 32'h0,        0, 32'hDEADBEEF, 0, 0});
        add(vec_t'{1, 32'h4, 0, 0, 32'h0,   32'h0, 0, 0, 32'h11111111, 1, 0, 32'h4,   1, 32'h11111111, 0, 32'hDEADBEEF, 1, 0});
        // Load of 0x200 arriving during a fetch of 0x8
        add(vec_t'{1, 32'h8, 0, 0, 32'h0,   32'h0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        0, 32'hDEADBEEF, 0, 0});
        add(vec_t'{1, 32'h8, 1, 0, 32'h200, 32'h0, 0, 0, 32'h0,        1, 0, 32'h8,   0, 32'h0,        0, 32'hDEADBEEF, 0, 1});
        add(vec_t'{1, 32'h8, 1, 0, 32'h200, 32'h0, 0, 0, 32'h22222222, 1, 0, 32'h8,   1, 32'h22222222, 0, 32'hDEADBEEF, 0, 1});
        add(vec_t'{1, 32'h8, 1, 0, 32'h200, 32'h0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h22222222, 0, 32'hDEADBEEF, 0, 1});
        add(vec_t'{1, 32'h8, 1, 0, 32'h200, 32'h0, 0, 0, 32'h0,        1, 0, 32'h200, 1, 32'h22222222, 0, 32'hDEADBEEF, 0, 1});
        add(vec_t'{1, 32'h8, 1, 0, 32'h200, 32'h0, 0, 0, 32'h33333333, 1, 0, 32'h200, 1, 32'h22222222, 1, 32'h33333333, 1, 0});
        add(vec_t'{0, 32'h0, 0, 0, 32'h0,   32'h0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        0, 32'h33333333, 0, 0});
        // Flush in first busy cycle of fetch 0xC, then fetch of 0x40
        add(vec_t'{1, 32'hC,  0, 0, 32'h0, 32'h0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 32'h0,        0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h40, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0,        1, 0, 32'hC,  0, 32'h0,        0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 0, 32'h44444444, 1, 0, 32'hC,  0, 32'h0,        0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 32'h0,        0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,        1, 0, 32'h40, 0, 32'h0,        0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 0, 32'h55555555, 1, 0, 32'h40, 1, 32'h55555555, 0, 32'h33333333, 1, 0});
        // Flush coinciding with fetch completion
        add(vec_t'{1, 32'h44, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 32'h0,        0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h44, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,        1, 0, 32'h44, 0, 32'h0,        0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h44, 0, 0, 32'h0, 32'h0, 1, 0, 32'h66666666, 1, 0, 32'h44, 0, 32'h0,        0, 32'h33333333, 0, 0});
        add(vec_t'{0, 32'h0,  0, 0, 32'h0, 32'h0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 32'h0,        0, 32'h33333333, 0, 0});
        // Load-use stall while a fetch is held
        add(vec_t'{1, 32'h48, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0,        0, 0, 32'h0,  0, 32'h0,        0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h48, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0,        1, 0, 32'h48, 0, 32'h0,        0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h48, 0, 0, 32'h0, 32'h0, 0, 1, 32'h77777777, 1, 0, 32'h48, 1, 32'h77777777, 0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h48, 0, 0, 32'h0, 32'h0, 0, 1, 32'h99999999, 0, 0, 32'h0,  1, 32'h77777777, 0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h48, 0, 0, 32'h0, 32'h0, 0, 1, 32'h99999999, 0, 0, 32'h0,  1, 32'h77777777, 0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h48, 0, 0, 32'h0, 32'h0, 0, 1, 32'h99999999, 0, 0, 32'h0,  1, 32'h77777777, 0, 32'h33333333, 0, 0});
        add(vec_t'{1, 32'h48, 0, 0, 32'h0, 32'h0, 0, 0, 32'h99999999, 0, 0, 32'h0,  1, 32'h77777777, 0, 32'h33333333, 1, 0});
        add(vec_t'{0, 32'h0,  0, 0, 32'h0, 32'h0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 32'h0,        0, 32'h33333333, 0, 0});
        // Store to 0x104
        add(vec_t'{0, 32'h0, 1, 1, 32'h104, 32'hCAFEF00D, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0, 0, 32'h33333333, 0, 1});
        add(vec_t'{0, 32'h0, 1, 1, 32'h104, 32'hCAFEF00D, 0, 0, 32'h0,        1, 1, 32'h104, 0, 32'h0, 0, 32'h33333333, 0, 1});
        add(vec_t'{0, 32'h0, 1, 1, 32'h104, 32'hCAFEF00D, 0, 0, 32'hABCD0000, 1, 1, 32'h104, 0, 32'h0, 1, 32'hABCD0000, 0, 0});
        add(vec_t'{0, 32'h0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0, 0, 32'hABCD0000, 0, 0});

        // Levels during reset, with a data request pending
        rst = 1'b1;
        drive_idle();
        d_req = 1'b1;
        #1;
        chk("rst_mem_en", 0, 32'(mem_en), 32'h0);
        chk("rst_mem_stall", 0, 32'(mem_stall), 32'h1);
        chk("rst_i_ready", 0, 32'(i_ready), 32'h0);
        chk("rst_d_rdata", 0, d_rdata, 32'h0);
        chk("rst_PCwrite", 0, 32'(PCwrite), 32'h0);
        $display("reset: en=%b stall=%b i_ready=%b d_rdata=%h pcw=%b", mem_en, mem_stall, i_ready, d_rdata, PCwrite);
        repeat (2) @(negedge clk);
        drive_idle();
        rst = 1'b0;

        for (int k = 0; k < vq.size(); k++) begin
            apply(vq[k], k);
        end

        // Reset asserted mid-way through a store to 0x300
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h12345678;
        @(negedge clk);
        #1;
        chk("st_mem_en", 100, 32'(mem_en), 32'h1);
        chk("st_mem_we", 100, 32'(mem_we), 32'h1);
        chk("st_mem_addr", 100, mem_addr, 32'h300);
        chk("st_mem_wdata", 100, mem_wdata, 32'h12345678);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_mem_en", 101, 32'(mem_en), 32'h0);
        chk("arst_mem_we", 101, 32'(mem_we), 32'h0);
        chk("arst_mem_addr", 101, mem_addr, 32'h0);
        chk("arst_mem_wdata", 101, mem_wdata, 32'h0);
        chk("arst_mem_stall", 101, 32'(mem_stall), 32'h1);
        chk("arst_d_rdata", 101, d_rdata, 32'h0);
        $display("async reset: en=%b we=%b addr=%h stall=%b", mem_en, mem_we, mem_addr, mem_stall);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_mem_en", 102, 32'(mem_en), 32'h0);
        chk("post_rst_d_ready", 102, 32'(d_ready), 32'h0);

        // Fresh fetch after release: IDLE means ready on the third cycle
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h80;
        #1;
        chk("post_rst_grant_en", 103, 32'(mem_en), 32'h0);
        @(negedge clk);
        #1;
        chk("post_rst_busy_en", 104, 32'(mem_en), 32'h1);
        chk("post_rst_addr", 104, mem_addr, 32'h80);
        @(negedge clk);
        mem_rdata = 32'h0BADF00D;
        #1;
        chk("post_rst_i_ready", 105, 32'(i_ready), 32'h1);
        chk("post_rst_i_rdata", 105, i_rdata, 32'h0BADF00D);
        $display("post-reset fetch: i_ready=%b i_rdata=%h", i_ready, i_rdata);
        @(negedge clk);
        drive_idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
